// File: rtl/sprite_anim_seq.sv
// Fighter sprite animation sequencer: turns action requests and hit events into
// registered animation/frame codes for the sprite memory, one clock from input to output.
module sprite_anim_seq #(
  parameter int TICKS_PER_FRAME = 6,
  parameter int HIT_TICKS       = 4,
  parameter int JUMP_TICKS      = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [3:0] req_anim,
  input  logic       req_valid,
  input  logic       hit,
  output logic [3:0] selanim,
  output logic [1:0] selframe,
  output logic       busy,
  output logic       anim_done
);

  localparam logic [1:0] ST_LOOP    = 2'd0;
  localparam logic [1:0] ST_ONESHOT = 2'd1;
  localparam logic [1:0] ST_HIT     = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_anim;
  logic [1:0] r_frame;
  logic       r_busy;
  logic       r_done;

  logic [7:0] w_limit;
  logic       w_wrap;
  logic [7:0] w_cnt_next;
  logic       w_accept;
  logic       w_held;
  logic       w_hold_pose;

  always_comb begin
    w_limit = 8'(TICKS_PER_FRAME);
    if (r_anim == 4'd2)      w_limit = 8'(HIT_TICKS);
    else if (r_anim == 4'd3) w_limit = 8'(JUMP_TICKS);
  end

  assign w_wrap      = frame_tick && (r_cnt == w_limit - 8'd1);
  assign w_cnt_next  = !frame_tick ? r_cnt : (w_wrap ? 8'd0 : r_cnt + 8'd1);
  // Code 2 is reserved for hit and never accepted as a request.
  assign w_accept    = req_valid && (req_anim != 4'd2) && (req_anim <= 4'd9) &&
                       (req_anim != r_anim);
  assign w_held      = (r_anim == 4'd1) || (r_anim >= 4'd7);
  assign w_hold_pose = (r_anim >= 4'd7);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_LOOP;
      r_cnt   <= 8'd0;
      r_anim  <= 4'd0;
      r_frame <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (hit) begin
        r_state <= ST_HIT;
        r_anim  <= 4'd2;
        r_frame <= 2'd0;
        r_cnt   <= 8'd0;
        r_busy  <= 1'b1;
      end else if (r_state == ST_LOOP) begin
        if (w_accept) begin
          r_anim  <= req_anim;
          r_frame <= 2'd0;
          r_cnt   <= 8'd0;
          if (req_anim inside {[4'd3:4'd6]}) begin
            r_state <= ST_ONESHOT;
            r_busy  <= 1'b1;
          end
        end else if (!req_valid && w_held) begin
          r_anim  <= 4'd0;
          r_frame <= 2'd0;
          r_cnt   <= 8'd0;
        end else if (!w_hold_pose) begin
          r_cnt <= w_cnt_next;
          if (w_wrap) r_frame <= r_frame + 2'd1;
        end
      end else begin
        r_cnt <= w_cnt_next;
        if (w_wrap) begin
          if (r_frame == 2'd3) begin
            r_state <= ST_LOOP;
            r_anim  <= 4'd0;
            r_frame <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_frame <= r_frame + 2'd1;
          end
        end
      end
    end
  end

  assign selanim   = r_anim;
  assign selframe  = r_frame;
  assign busy      = r_busy;
  assign anim_done = r_done;

endmodule
